// File: rtl/csr_trap_seq.sv
// Trap-entry / mret sequencer: drives a combinational-read CSR port through
// mepc/mcause/mstatus/mtvec updates, then issues a one-cycle PC redirect.
module csr_trap_seq #(
    parameter logic [11:0] ADDR_MSTATUS = 12'h000,
    parameter logic [11:0] ADDR_MEPC    = 12'h041,
    parameter logic [11:0] ADDR_MCAUSE  = 12'h042,
    parameter logic [11:0] ADDR_MTVEC   = 12'h005
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    output logic        req_ack,
    output logic        busy,
    output logic        csr_w,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [3:0] {
        IDLE, T_MEPC, T_MCAUSE, T_RSTAT, T_WSTAT, T_RVEC,
        M_REPC, M_RSTAT, M_WSTAT, REDIR
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state, state_next;
    logic [31:0] pc_q, cause_q, status_q, target_q, redirect_pc_q;
    logic [31:0] rdata_aligned;

    assign rdata_aligned = csr_rdata & WORD_MASK;
    assign busy          = (state != IDLE);
    assign redirect_pc   = redirect_pc_q;

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        req_ack        = 1'b0;
        csr_w          = 1'b0;
        csr_addr       = ADDR_MSTATUS;
        csr_wdata      = 32'h0;
        redirect_valid = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gate keeps the accept pulse quiet while held in reset.
                if (rst_n && trap_req) begin
                    req_ack    = 1'b1;
                    state_next = T_MEPC;
                end else if (rst_n && mret_req) begin
                    req_ack    = 1'b1;
                    state_next = M_REPC;
                end
            end
            T_MEPC: begin
                csr_w      = 1'b1;
                csr_addr   = ADDR_MEPC;
                csr_wdata  = pc_q & WORD_MASK;
                state_next = T_MCAUSE;
            end
            T_MCAUSE: begin
                csr_w      = 1'b1;
                csr_addr   = ADDR_MCAUSE;
                csr_wdata  = cause_q;
                state_next = T_RSTAT;
            end
            T_RSTAT: begin
                csr_addr   = ADDR_MSTATUS;
                state_next = T_WSTAT;
            end
            T_WSTAT: begin
                csr_w        = 1'b1;
                csr_addr     = ADDR_MSTATUS;
                csr_wdata    = status_q;
                csr_wdata[7] = status_q[3];
                csr_wdata[3] = 1'b0;
                state_next   = T_RVEC;
            end
            T_RVEC: begin
                csr_addr   = ADDR_MTVEC;
                state_next = REDIR;
            end
            M_REPC: begin
                csr_addr   = ADDR_MEPC;
                state_next = M_RSTAT;
            end
            M_RSTAT: begin
                csr_addr   = ADDR_MSTATUS;
                state_next = M_WSTAT;
            end
            M_WSTAT: begin
                csr_w        = 1'b1;
                csr_addr     = ADDR_MSTATUS;
                csr_wdata    = status_q;
                csr_wdata[3] = status_q[7];
                csr_wdata[7] = 1'b1;
                state_next   = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state and latches use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc_q          <= 32'h0;
            cause_q       <= 32'h0;
            status_q      <= 32'h0;
            target_q      <= 32'h0;
            redirect_pc_q <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        pc_q    <= trap_pc;
                        cause_q <= trap_cause;
                    end
                end
                T_RSTAT, M_RSTAT: status_q <= csr_rdata;
                // Loading redirect_pc on the edge into REDIR keeps it stable
                // in every other cycle.
                T_RVEC: begin
                    target_q      <= rdata_aligned;
                    redirect_pc_q <= rdata_aligned;
                end
                M_REPC:  target_q      <= rdata_aligned;
                M_WSTAT: redirect_pc_q <= target_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Scoreboard bench for csr_trap_seq: a CSR-array slave, a transaction-level
// reference model that predicts writes/redirects on accept, and a monitor.
module tb_csr_trap_seq;

    localparam logic [11:0] A_MST    = 12'h000;
    localparam logic [11:0] A_MEPC   = 12'h041;
    localparam logic [11:0] A_MCAUSE = 12'h042;
    localparam logic [11:0] A_MTVEC  = 12'h005;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_req, mret_req;
    logic [31:0] trap_cause, trap_pc;
    logic        req_ack, busy, csr_w, redirect_valid;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata, redirect_pc;

    csr_trap_seq dut (
        .clk(clk), .rst_n(rst_n),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_req(mret_req), .req_ack(req_ack), .busy(busy),
        .csr_w(csr_w), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // CSR slave as seen by the DUT, and the model's own view of the CSRs.
    logic [31:0] bus_csr [0:4095];
    logic [31:0] sh_csr  [0:4095];
    assign csr_rdata = bus_csr[csr_addr];

    typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] pc;   int cyc;           } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    int          total = 0, bad = 0;
    int          cyc = 0, free_at = 0;
    logic [31:0] last_redir = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && csr_w) bus_csr[csr_addr] <= csr_wdata;
    end

    // Reference model + monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ack", 32'(req_ack), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_csr_w", 32'(csr_w), 0);
            check("rst_redirect_valid", 32'(redirect_valid), 0);
            check("rst_csr_wdata", csr_wdata, 0);
            check("rst_redirect_pc", redirect_pc, 0);
            wq.delete();
            rq.delete();
            free_at    = 0;
            last_redir = 32'h0;
        end else begin
            logic exp_busy, exp_ack;
            exp_busy = (cyc < free_at);
            exp_ack  = !exp_busy && (trap_req || mret_req);
            check("req_ack", 32'(req_ack), 32'(exp_ack));
            check("busy", 32'(busy), 32'(exp_busy));
            if (!exp_busy) check("idle_addr", 32'(csr_addr), 32'(A_MST));
            if (exp_ack) begin
                logic [31:0] s, ns;
                s = sh_csr[A_MST];
                if (trap_req) begin
                    ns = s;
                    ns[7] = s[3];
                    ns[3] = 1'b0;
                    wq.push_back('{A_MEPC, trap_pc & 32'hFFFF_FFFC});
                    wq.push_back('{A_MCAUSE, trap_cause});
                    wq.push_back('{A_MST, ns});
                    rq.push_back('{sh_csr[A_MTVEC] & 32'hFFFF_FFFC, cyc + 6});
                    free_at = cyc + 7;
                end else begin
                    ns = s;
                    ns[3] = s[7];
                    ns[7] = 1'b1;
                    wq.push_back('{A_MST, ns});
                    rq.push_back('{sh_csr[A_MEPC] & 32'hFFFF_FFFC, cyc + 4});
                    free_at = cyc + 5;
                end
            end
            if (csr_w) begin
                if (wq.size() == 0) flag("csr_write");
                else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("write_addr", 32'(csr_addr), 32'(e.addr));
                    check("write_data", csr_wdata, e.data);
                    sh_csr[e.addr] = e.data;
                end
            end else begin
                check("wdata_zero", csr_wdata, 0);
            end
            if (redirect_valid) begin
                if (rq.size() == 0) flag("redirect");
                else begin
                    rd_t r;
                    r = rq.pop_front();
                    check("redirect_pc", redirect_pc, r.pc);
                    check("redirect_cycle", 32'(cyc), 32'(r.cyc));
                    last_redir = r.pc;
                end
            end else begin
                check("redirect_hold", redirect_pc, last_redir);
            end
        end
    end

    task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
        bus_csr[a] = v;
        sh_csr[a]  = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input int n, input logic t, input logic m,
                         input logic [31:0] pc, input logic [31:0] cause);
        trap_req = t; mret_req = m; trap_pc = pc; trap_cause = cause;
        idle(n);
        trap_req = 1'b0; mret_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) set_csr(12'(i), 32'h0);
        rst_n = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
        trap_pc = 32'h0; trap_cause = 32'h0;
        set_csr(A_MST, 32'h0000_0008);
        set_csr(A_MTVEC, 32'h0000_0101);
        idle(3);
        rst_n = 1'b1;

        // Basic trap entry
        drive(1, 1'b1, 1'b0, 32'h0000_0046, 32'h0000_000B);
        idle(8);
        check("t031_mepc", bus_csr[A_MEPC], 32'h0000_0044);
        check("t031_mcause", bus_csr[A_MCAUSE], 32'h0000_000B);
        check("t031_mstatus", bus_csr[A_MST], 32'h0000_0080);
        check("t031_redirect", redirect_pc, 32'h0000_0100);

        // Basic mret
        set_csr(A_MEPC, 32'h0000_0200);
        set_csr(A_MST, 32'h0000_0080);
        drive(1, 1'b0, 1'b1, 32'h0, 32'h0);
        idle(6);
        check("t032_mstatus", bus_csr[A_MST], 32'h0000_0088);
        check("t032_redirect", redirect_pc, 32'h0000_0200);

        // Simultaneous trap and mret: trap wins
        drive(1, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0005);
        idle(8);
        check("t033_mepc", bus_csr[A_MEPC], 32'h0000_1234);
        check("t033_mcause", bus_csr[A_MCAUSE], 32'h0000_0005);

        // Trap pulsed while busy is ignored
        drive(1, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_0003);
        idle(2);
        drive(1, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_0007);
        idle(8);
        check("t034_mepc", bus_csr[A_MEPC], 32'h0000_3000);

        // Back-to-back trap, mret, trap with requests held high
        set_csr(A_MTVEC, 32'h0000_8002);
        drive(7, 1'b1, 1'b0, 32'h0000_5557, 32'h8000_0007);
        drive(5, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_0002);
        idle(8);
        check("t036_mepc", bus_csr[A_MEPC], 32'h0000_6000);
        check("t036_redirect", redirect_pc, 32'h0000_8000);

        // Reset while in T_RSTAT
        set_csr(A_MST, 32'h0000_0008);
        drive(1, 1'b1, 1'b0, 32'h0000_7000, 32'h0000_0004);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("t035_csr_w", 32'(csr_w), 0);
        check("t035_busy", 32'(busy), 0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("t035_mstatus", bus_csr[A_MST], 32'h0000_0008);
        check("t035_mepc", bus_csr[A_MEPC], 32'h0000_7000);

        // Randomized segments
        for (int seg = 0; seg < 10; seg++) begin
            set_csr(A_MST, $urandom);
            set_csr(A_MTVEC, $urandom);
            set_csr(A_MEPC, $urandom);
            for (int k = 0; k < 150; k++) begin
                drive(1, ($urandom % 6) == 0, ($urandom % 5) == 0, $urandom, $urandom);
            end
            idle(10);
        end

        check("queues_drained", 32'(wq.size() + rq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_trap_seq.md
CSR_TRAP_SEQ -- requirements
Module: csr_trap_seq

Interface
REQ-001 SHALL have parameter ADDR_MSTATUS, default 12'h000, meaning the mstatus CSR address.
REQ-002 SHALL have parameter ADDR_MEPC, default 12'h041, meaning the mepc CSR address.
REQ-003 SHALL have parameter ADDR_MCAUSE, default 12'h042, meaning the mcause CSR address.
REQ-004 SHALL have parameter ADDR_MTVEC, default 12'h005, meaning the mtvec CSR address.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trap_req  in  1  trap request (ecall, ebreak, exception).
- trap_cause  in  32  mcause value, sampled on accept.
- trap_pc  in  32  faulting PC, sampled on accept.
- mret_req  in  1  mret request.
- req_ack  out  1  one-cycle accept pulse.
- busy  out  1  sequence in progress, core stalls while high.
- csr_w  out  1  CSR write strobe, committed at the next rising edge.
- csr_addr  out  12  CSR address.
- csr_wdata  out  32  CSR write data.
- csr_rdata  in  32  combinational read data for csr_addr.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  redirect target.

Function
REQ-006 SHALL act as CSR initiator: reads are combinational (drive csr_addr, capture csr_rdata at the same rising edge); writes assert csr_w with csr_addr/csr_wdata for exactly one cycle.
REQ-007 SHALL implement FSM states IDLE, T_MEPC, T_MCAUSE, T_RSTAT, T_WSTAT, T_RVEC, M_REPC, M_RSTAT, M_WSTAT, REDIR.
REQ-008 In IDLE, with trap_req=1, SHALL assert req_ack, latch trap_pc and trap_cause, and go to T_MEPC.
REQ-009 In IDLE, with mret_req=1 and trap_req=0, SHALL assert req_ack and go to M_REPC.
REQ-010 SHALL give trap_req priority when trap_req and mret_req are both high; the mret is dropped and not queued.
REQ-011 SHALL ignore and not queue requests in any state other than IDLE.
REQ-012 T_MEPC SHALL write ADDR_MEPC with {pc[31:2],2'b00}, then go to T_MCAUSE.
REQ-013 T_MCAUSE SHALL write ADDR_MCAUSE with the latched cause, then go to T_RSTAT.
REQ-014 T_RSTAT SHALL read ADDR_MSTATUS into a status latch, then go to T_WSTAT.
REQ-015 T_WSTAT SHALL write ADDR_MSTATUS with the status latch modified as bit7(MPIE)=bit3(MIE) and bit3=0, other bits unchanged, then go to T_RVEC.
REQ-016 T_RVEC SHALL read ADDR_MTVEC and latch the target as {rdata[31:2],2'b00}, then go to REDIR.
REQ-017 M_REPC SHALL read ADDR_MEPC and latch the target as {rdata[31:2],2'b00}, then go to M_RSTAT.
REQ-018 M_RSTAT SHALL read ADDR_MSTATUS, then go to M_WSTAT.
REQ-019 M_WSTAT SHALL write ADDR_MSTATUS with bit3=bit7 and bit7=1, other bits unchanged, then go to REDIR.
REQ-020 REDIR SHALL assert redirect_valid for one cycle with redirect_pc equal to the target, then go to IDLE.
REQ-021 SHALL run the trap sequence as 1 accept cycle plus 6 cycles (total 7), and the mret sequence as 1 accept cycle plus 4 cycles (total 5).
REQ-022 busy SHALL be 1 in every non-IDLE state, including REDIR, and 0 in IDLE.
REQ-023 A new request SHALL be acceptable in the cycle after REDIR.
REQ-024 When csr_w=0, SHALL drive csr_wdata=0.
REQ-025 When not in a read or write state, SHALL drive csr_addr=ADDR_MSTATUS.
REQ-026 redirect_pc SHALL hold its last value while redirect_valid=0.

Reset
REQ-027 On rst_n=0, SHALL asynchronously enter IDLE.
REQ-028 On rst_n=0, SHALL drive csr_w, req_ack, busy and redirect_valid to 0, and csr_wdata, redirect_pc and all latches to 0.
REQ-029 Reset mid-sequence SHALL abort with no further CSR writes, no redirect, and no resumption after release.
REQ-030 SHALL accept requests from the first rising edge after rst_n deasserts.

Verification
REQ-031 Trap: mstatus=0x00000008, mtvec=0x00000101, trap_req with pc=0x00000046 and cause=0x0000000B -> mepc=0x00000044, mcause=0x0000000B, mstatus=0x00000080, and redirect_pc=0x00000100 exactly 6 cycles after req_ack.
REQ-032 Mret: mepc=0x00000200, mstatus=0x00000080 -> mstatus=0x00000088, and redirect_pc=0x00000200 4 cycles after req_ack.
REQ-033 Simultaneous trap_req and mret_req in IDLE -> trap sequence only, and mepc is written with the trap PC.
REQ-034 trap_req pulsed during busy -> no second req_ack and exactly one redirect_valid pulse.
REQ-035 rst_n=0 asserted in T_RSTAT -> csr_w=0 immediately, mstatus unmodified, and no redirect_valid after release.
REQ-036 Back-to-back trap, mret, trap -> each req_ack lands on the cycle after the previous redirect_valid, with correct CSR values each time.
